// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and constants for the CPU pipeline control logic.
package cpu_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MISS = 2'd2,
    HALT = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// One-cycle update latency; no backpressure, holds at all-ones once full.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush/bubble sequencer for the 5-stage pipeline with miss watchdog and perf counters.
// Controls are combinational in the cycle of the cause; dcache miss freezes every stage.
module pipeline_stall_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MISS_TIMEOUT = 1023,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             dcache_stall_i,
  input  logic             id_ex_memread_i,
  input  logic [REG_W-1:0] id_ex_rd_i,
  input  logic [REG_W-1:0] if_id_rs_i,
  input  logic [REG_W-1:0] if_id_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  output logic             pc_stall_o,
  output logic             pc_enable_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_stall_o,
  output logic             mem_wb_stall_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic             timeout_o
);

  localparam int WD_W = $clog2(MISS_TIMEOUT + 1);

  state_e          state_d, state_q;
  logic            timeout_d, timeout_q;
  logic            lu, miss, in_run, in_miss, active;
  logic            wd_hit, miss_entry, wd_clr;
  logic [WD_W-1:0] wd_cnt;

  assign in_run  = (state_q == RUN);
  assign in_miss = (state_q == MISS);
  assign active  = in_run || in_miss;

  assign lu = id_ex_memread_i && (id_ex_rd_i != REG_ZERO) &&
              ((id_ex_rd_i == if_id_rs_i) || (id_ex_rd_i == if_id_rt_i));
  assign miss = dcache_stall_i || in_miss;

  assign wd_hit     = active && (wd_cnt >= WD_W'(MISS_TIMEOUT));
  assign miss_entry = in_run && dcache_stall_i && start_i && !wd_hit;
  assign wd_clr     = !dcache_stall_i || !active || !start_i;

  always_comb begin
    pc_stall_o     = 1'b0;
    pc_enable_o    = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    ex_mem_stall_o = 1'b0;
    mem_wb_stall_o = 1'b0;
    case (state_q)
      IDLE: if_id_flush_o = 1'b1;
      RUN: begin
        // Miss outranks load-use, which outranks a redirect flush.
        if (miss) begin
          pc_stall_o     = 1'b1;
          if_id_stall_o  = 1'b1;
          ex_mem_stall_o = 1'b1;
          mem_wb_stall_o = 1'b1;
        end else if (lu) begin
          pc_stall_o     = 1'b1;
          if_id_stall_o  = 1'b1;
          id_ex_bubble_o = 1'b1;
        end else if (branch_taken_i || jump_i) begin
          if_id_flush_o  = 1'b1;
        end
        pc_enable_o = !pc_stall_o;
      end
      MISS, HALT: begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        ex_mem_stall_o = 1'b1;
        mem_wb_stall_o = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN, MISS: begin
        // A watchdog expiry is an error and takes precedence over a stop.
        if (wd_hit) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end else if (!start_i) begin
          state_d = IDLE;
        end else if (in_run && dcache_stall_i) begin
          state_d = MISS;
        end else if (in_miss && !dcache_stall_i) begin
          state_d = RUN;
        end
      end
      HALT: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (active && pc_stall_o),
    .clr_i (1'b0),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (miss_entry),
    .clr_i (1'b0),
    .cnt_o (miss_cnt_o)
  );

  sat_counter #(.W(WD_W)) u_watchdog (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (active && dcache_stall_i),
    .clr_i (wd_clr),
    .cnt_o (wd_cnt)
  );

  assign state_o   = state_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: a default instance and a small one (MISS_TIMEOUT=4, CNT_W=2) share stimulus.
module tb_pipeline_stall_ctrl;

  logic       clk_i, rst_i, start_i, dcache_stall_i, id_ex_memread_i;
  logic [4:0] id_ex_rd_i, if_id_rs_i, if_id_rt_i;
  logic       branch_taken_i, jump_i;

  logic        a_pc_stall, a_pc_en, a_ifid_stall, a_flush, a_bubble, a_exmem, a_memwb, a_timeout;
  logic [1:0]  a_state;
  logic [15:0] a_stall_cnt, a_miss_cnt;
  logic        b_pc_stall, b_pc_en, b_ifid_stall, b_flush, b_bubble, b_exmem, b_memwb, b_timeout;
  logic [1:0]  b_state;
  logic [1:0]  b_stall_cnt, b_miss_cnt;

  // Control vector order: {pc_stall, pc_enable, if_id_stall, flush, bubble, ex_mem_stall, mem_wb_stall}
  logic [6:0] ctl_a, ctl_b;
  assign ctl_a = {a_pc_stall, a_pc_en, a_ifid_stall, a_flush, a_bubble, a_exmem, a_memwb};
  assign ctl_b = {b_pc_stall, b_pc_en, b_ifid_stall, b_flush, b_bubble, b_exmem, b_memwb};

  localparam logic [6:0] C_IDLE  = 7'b0001000;
  localparam logic [6:0] C_RUN   = 7'b0100000;
  localparam logic [6:0] C_LU    = 7'b1010100;
  localparam logic [6:0] C_FLUSH = 7'b0101000;
  localparam logic [6:0] C_MISS  = 7'b1010011;

  pipeline_stall_ctrl dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .dcache_stall_i(dcache_stall_i),
    .id_ex_memread_i(id_ex_memread_i), .id_ex_rd_i(id_ex_rd_i), .if_id_rs_i(if_id_rs_i),
    .if_id_rt_i(if_id_rt_i), .branch_taken_i(branch_taken_i), .jump_i(jump_i),
    .pc_stall_o(a_pc_stall), .pc_enable_o(a_pc_en), .if_id_stall_o(a_ifid_stall),
    .if_id_flush_o(a_flush), .id_ex_bubble_o(a_bubble), .ex_mem_stall_o(a_exmem),
    .mem_wb_stall_o(a_memwb), .state_o(a_state), .stall_cnt_o(a_stall_cnt),
    .miss_cnt_o(a_miss_cnt), .timeout_o(a_timeout));

  pipeline_stall_ctrl #(.MISS_TIMEOUT(4), .CNT_W(2)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .dcache_stall_i(dcache_stall_i),
    .id_ex_memread_i(id_ex_memread_i), .id_ex_rd_i(id_ex_rd_i), .if_id_rs_i(if_id_rs_i),
    .if_id_rt_i(if_id_rt_i), .branch_taken_i(branch_taken_i), .jump_i(jump_i),
    .pc_stall_o(b_pc_stall), .pc_enable_o(b_pc_en), .if_id_stall_o(b_ifid_stall),
    .if_id_flush_o(b_flush), .id_ex_bubble_o(b_bubble), .ex_mem_stall_o(b_exmem),
    .mem_wb_stall_o(b_memwb), .state_o(b_state), .stall_cnt_o(b_stall_cnt),
    .miss_cnt_o(b_miss_cnt), .timeout_o(b_timeout));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       mr;
    logic [4:0] rd, rs, rt;
    logic       br, jmp;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    start_i = 1'b0; dcache_stall_i = 1'b0; id_ex_memread_i = 1'b0;
    id_ex_rd_i = '0; if_id_rs_i = '0; if_id_rt_i = '0;
    branch_taken_i = 1'b0; jump_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_inputs();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
  endtask

  initial begin
    int exp_stall;
    int nstall;
    int nmiss;
    rst_i = 1'b1;
    clear_inputs();
    vecs[0] = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, C_RUN};
    vecs[1] = '{1'b1, 5'd5,  5'd5, 5'd0,  1'b0, 1'b0, C_LU};
    vecs[2] = '{1'b0, 5'd5,  5'd5, 5'd0,  1'b0, 1'b0, C_RUN};
    vecs[3] = '{1'b1, 5'd8,  5'd0, 5'd8,  1'b1, 1'b0, C_LU};
    vecs[4] = '{1'b0, 5'd8,  5'd0, 5'd8,  1'b1, 1'b0, C_FLUSH};
    vecs[5] = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b1, C_FLUSH};
    vecs[6] = '{1'b1, 5'd0,  5'd0, 5'd0,  1'b1, 1'b0, C_FLUSH};
    vecs[7] = '{1'b1, 5'd31, 5'd3, 5'd31, 1'b0, 1'b1, C_LU};
    vecs[8] = '{1'b1, 5'd7,  5'd6, 5'd8,  1'b0, 1'b0, C_RUN};

    // Reset state and IDLE -> RUN
    do_reset();
    chk("reset_state", 32'(a_state), 32'd0);
    chk("reset_ctl", 32'(ctl_a), 32'(C_IDLE));
    chk("reset_stall_cnt", 32'(a_stall_cnt), 32'd0);
    chk("reset_miss_cnt", 32'(a_miss_cnt), 32'd0);
    chk("reset_timeout", 32'(a_timeout), 32'd0);
    start_i = 1'b1;
    tick();
    chk("start_state", 32'(a_state), 32'd1);
    chk("start_ctl", 32'(ctl_a), 32'(C_RUN));
    chk("start_stall_cnt", 32'(a_stall_cnt), 32'd0);

    // Priority table in RUN
    exp_stall = 0;
    for (int i = 0; i < 9; i++) begin
      id_ex_memread_i = vecs[i].mr; id_ex_rd_i = vecs[i].rd;
      if_id_rs_i = vecs[i].rs; if_id_rt_i = vecs[i].rt;
      branch_taken_i = vecs[i].br; jump_i = vecs[i].jmp;
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl_a), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_state", i), 32'(a_state), 32'd1);
      chk($sformatf("vec%0d_stall_cnt", i), 32'(a_stall_cnt), 32'(exp_stall));
      if (vecs[i].exp[6]) exp_stall++;
      tick();
    end
    clear_inputs();
    start_i = 1'b1;
    #1;
    chk("table_stall_cnt", 32'(a_stall_cnt), 32'(exp_stall));
    chk("table_miss_cnt", 32'(a_miss_cnt), 32'd0);

    // Miss: stalls visible for 10 cycles, branch held but ignored until RUN resumes
    do_reset();
    start_i = 1'b1;
    tick();
    branch_taken_i = 1'b1;
    nstall = 0;
    nmiss = 0;
    for (int i = 0; i < 10; i++) begin
      dcache_stall_i = (i < 9);
      #1;
      if (ctl_a == C_MISS) nstall++;
      if (a_state == 2'd2) nmiss++;
      tick();
    end
    #1;
    chk("miss_stall_cycles", 32'(nstall), 32'd10);
    chk("miss_state_cycles", 32'(nmiss), 32'd9);
    chk("miss_resume_state", 32'(a_state), 32'd1);
    chk("miss_resume_ctl", 32'(ctl_a), 32'(C_FLUSH));
    chk("miss_cnt", 32'(a_miss_cnt), 32'd1);
    chk("miss_stall_cnt", 32'(a_stall_cnt), 32'd10);
    branch_taken_i = 1'b0;
    tick();
    chk("miss_after_flush_ctl", 32'(ctl_a), 32'(C_RUN));

    // Watchdog on the MISS_TIMEOUT=4 instance
    do_reset();
    start_i = 1'b1;
    tick();
    dcache_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("wd_pre_state", 32'(b_state), 32'd2);
    chk("wd_pre_timeout", 32'(b_timeout), 32'd0);
    tick();
    chk("wd_halt_state", 32'(b_state), 32'd3);
    chk("wd_halt_timeout", 32'(b_timeout), 32'd1);
    chk("wd_halt_ctl", 32'(ctl_b), 32'(C_MISS));
    dcache_stall_i = 1'b0;
    tick();
    chk("wd_dc_low_state", 32'(b_state), 32'd3);
    chk("wd_dc_low_timeout", 32'(b_timeout), 32'd1);
    start_i = 1'b0;
    tick();
    chk("wd_stop_state", 32'(b_state), 32'd3);
    chk("wd_stop_timeout", 32'(b_timeout), 32'd1);
    start_i = 1'b1;
    tick();
    chk("wd_restart_state", 32'(b_state), 32'd3);
    do_reset();
    chk("wd_reset_state", 32'(b_state), 32'd0);
    chk("wd_reset_timeout", 32'(b_timeout), 32'd0);

    // Stop in the middle of a miss
    start_i = 1'b1;
    tick();
    dcache_stall_i = 1'b1;
    tick();
    chk("stop_in_miss_state", 32'(a_state), 32'd2);
    start_i = 1'b0;
    tick();
    chk("stop_idle_state", 32'(a_state), 32'd0);
    chk("stop_idle_ctl", 32'(ctl_a), 32'(C_IDLE));
    dcache_stall_i = 1'b0;

    // Stall counter saturation on the CNT_W=2 instance
    do_reset();
    start_i = 1'b1;
    tick();
    id_ex_memread_i = 1'b1; id_ex_rd_i = 5'd5; if_id_rs_i = 5'd5;
    #1;
    chk("sat_lu_ctl", 32'(ctl_b), 32'(C_LU));
    tick();
    tick();
    chk("sat_cnt_2", 32'(b_stall_cnt), 32'd2);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_cnt_5", 32'(b_stall_cnt), 32'd3);
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
